// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op codes, FSM state
// encoding and the counter-width helper.
package alu_pkg;

    localparam logic [1:0] OP_SUM = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit-step counter width; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/alu_serial_seq_alu1.sv
// ALU1: combinational 1-bit ALU slice (sum/and/or/xor with optional B inversion).
module ALU1
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       b_inv,
    input  logic       y,
    input  logic [1:0] op,
    output logic       s,
    output logic       c
);

    logic w_eb;

    assign w_eb = b ^ b_inv;
    assign c    = (a & w_eb) | ((a ^ w_eb) & y);

    always_comb begin
        s = 1'b0;
        case (op)
            OP_SUM:  s = a ^ w_eb ^ y;
            OP_AND:  s = a & w_eb;
            OP_OR:   s = a | w_eb;
            OP_XOR:  s = a ^ w_eb;
            default: s = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer driving one ALU1 slice LSB-first, WIDTH cycles per op.
// Optional signed-overflow flag enabled by defining ALU_SERIAL_OVF_EN.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_binv,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             out_z,
    output logic             out_v,
    output logic             busy
);

    localparam int CNT_W = cnt_w(WIDTH);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [1:0]       r_op;
    logic             r_binv;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    // Only WIDTH-1 bits are kept: the MSB of the result arrives straight from the slice.
    logic [WIDTH-2:0] r_res;
    logic [WIDTH-1:0] r_out_s;
    logic             r_out_c;
    logic             r_out_z;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-2:0] w_res_shift;
    logic [WIDTH-1:0] w_res_final;

    ALU1 u_alu1 (
        .a     (r_a_sr[0]),
        .b     (r_b_sr[0]),
        .b_inv (r_binv),
        .y     (r_carry),
        .op    (r_op),
        .s     (w_s),
        .c     (w_c)
    );

    generate
        if (WIDTH == 2) begin : g_res_w2
            assign w_res_shift = w_s;
        end else begin : g_res_wn
            assign w_res_shift = {w_s, r_res[WIDTH-2:1]};
        end
    endgenerate

    assign w_res_final = {w_s, r_res};
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_op    <= OP_SUM;
            r_binv  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_out_s <= '0;
            r_out_c <= 1'b0;
            r_out_z <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a_sr  <= in_a;
                        r_b_sr  <= in_b;
                        r_op    <= in_op;
                        r_binv  <= in_binv;
                        r_carry <= in_cin;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_res   <= w_res_shift;
                    if (w_last) begin
                        r_out_s <= w_res_final;
                        r_out_c <= (r_op == OP_SUM) ? w_c : 1'b0;
                        r_out_z <= (w_res_final == '0);
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_SERIAL_OVF_EN
    // During the MSB step the carry flop holds the slice's y input (cy_msb),
    // so overflow is its XOR with the carry leaving the MSB.
    logic r_out_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_v <= 1'b0;
        end else if (r_state == ST_RUN && w_last) begin
            r_out_v <= (r_op == OP_SUM) & (r_carry ^ w_c);
        end
    end

    assign out_v = r_out_v;
`else
    assign out_v = 1'b0;
`endif

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_s     = r_out_s;
    assign out_c     = r_out_c;
    assign out_z     = r_out_z;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq (WIDTH=4); expected values come from an
// arithmetic reference model. Overflow expectations follow ALU_SERIAL_OVF_EN.
module tb_alu_serial_seq;

    localparam int W = 4;

`ifdef ALU_SERIAL_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [1:0]   in_op = 2'b00;
    logic         in_binv = 1'b0;
    logic         in_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_s;
    logic         out_c;
    logic         out_z;
    logic         out_v;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_binv   (in_binv),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_c     (out_c),
        .out_z     (out_z),
        .out_v     (out_v),
        .busy      (busy)
    );

    // Reference: whole-word arithmetic, packed as {s, c, z, v}.
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op, input logic binv, input logic cin);
        logic [W-1:0] eb;
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         c;
        logic         v;
        eb = binv ? ~b : b;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            2'b00: begin
                full = {1'b0, a} + {1'b0, eb} + {{W{1'b0}}, cin};
                s    = full[W-1:0];
                c    = full[W];
                v    = OVF_EN && (a[W-1] == eb[W-1]) && (s[W-1] != a[W-1]);
            end
            2'b01:   s = a & eb;
            2'b10:   s = a | eb;
            default: s = a ^ eb;
        endcase
        return {s, c, (s == '0), v};
    endfunction

    // Launch one op and wait (bounded) for out_valid; leaves out_ready low.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                          input logic binv, input logic cin, output int lat);
        @(negedge clk);
        in_a = a; in_b = b; in_op = op; in_binv = binv; in_cin = cin;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        $display("op=%0d a=%h b=%h binv=%b cin=%b -> s=%h c=%b z=%b v=%b lat=%0d",
                 op, a, b, binv, cin, out_s, out_c, out_z, out_v, lat);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({in_ready, out_valid, busy, out_s, out_c, out_z, out_v} !== {3'b100, {W{1'b0}}, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b s=%h c=%b z=%b v=%b, want rdy=1 others 0",
                     in_ready, out_valid, busy, out_s, out_c, out_z, out_v);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        run_op(4'h7, 4'h5, 2'b00, 1'b0, 1'b0, lat);
        n_chk++;
        if (lat !== W) begin
            n_fail++;
            $display("FAIL add_latency: got %0d want %0d", lat, W);
        end
        n_chk++;
        if ({out_s, out_c, out_z, out_v} !== {4'hC, 1'b0, 1'b0, OVF_EN}) begin
            n_fail++;
            $display("FAIL add_7_5: got s=%h c=%b z=%b v=%b want s=c c=0 z=0 v=%b",
                     out_s, out_c, out_z, out_v, OVF_EN);
        end
        n_chk++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL done_handshake: got in_ready=%b busy=%b want 0 1", in_ready, busy);
        end
        consume();
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_idle: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_sub();
        int lat;
        run_op(4'h3, 4'h3, 2'b00, 1'b1, 1'b1, lat);
        n_chk++;
        if ({out_s, out_c, out_z, out_v} !== 7'b0000_110) begin
            n_fail++;
            $display("FAIL sub_3_3: got s=%h c=%b z=%b v=%b want s=0 c=1 z=1 v=0", out_s, out_c, out_z, out_v);
        end
        consume();
        run_op(4'hF, 4'h1, 2'b00, 1'b0, 1'b0, lat);
        n_chk++;
        if ({out_s, out_c, out_z, out_v} !== 7'b0000_110) begin
            n_fail++;
            $display("FAIL add_f_1: got s=%h c=%b z=%b v=%b want s=0 c=1 z=1 v=0", out_s, out_c, out_z, out_v);
        end
        consume();
    endtask

    task automatic test_logic();
        logic [1:0]   ops  [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
        logic         binvs[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] exps [4] = '{4'h8, 4'hE, 4'h6, 4'h4};
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(4'hC, 4'hA, ops[i], binvs[i], 1'b1, lat);
            n_chk++;
            if ({out_s, out_c, out_z, out_v} !== {exps[i], 3'b000}) begin
                n_fail++;
                $display("FAIL logic_op%0d_binv%0d: got s=%h c=%b z=%b v=%b want s=%h c=0 z=0 v=0",
                         ops[i], binvs[i], out_s, out_c, out_z, out_v, exps[i]);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W+2:0] exp;
        run_op(4'h9, 4'h4, 2'b00, 1'b0, 1'b0, lat);
        exp = model(4'h9, 4'h4, 2'b00, 1'b0, 1'b0);
        in_a = 4'h1; in_b = 4'h1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_s, out_c, out_z, out_v} !== exp) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b s=%h c=%b z=%b v=%b want vld=1 rdy=0 {s,c,z,v}=%h",
                         i, out_valid, in_ready, out_s, out_c, out_z, out_v, exp);
            end
        end
        in_valid = 1'b0;
        consume();
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || {out_s, out_c, out_z, out_v} !== exp) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b rdy=%b busy=%b s=%h want vld=0 rdy=1 busy=0 held s",
                     out_valid, in_ready, busy, out_s);
        end
        run_op(4'h6, 4'h2, 2'b11, 1'b0, 1'b0, lat);
        n_chk++;
        if (lat !== W || out_s !== 4'h4) begin
            n_fail++;
            $display("FAIL bp_ignored_pulse: got lat=%0d s=%h want lat=%0d s=4", lat, out_s, W);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        in_a = 4'hE; in_b = 4'h7; in_op = 2'b00; in_binv = 1'b0; in_cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if ({in_ready, out_valid, busy, out_s, out_c, out_z, out_v} !== {3'b100, {W{1'b0}}, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_mid: got rdy=%b vld=%b busy=%b s=%h c=%b z=%b v=%b want rdy=1 others 0",
                     in_ready, out_valid, busy, out_s, out_c, out_z, out_v);
        end
        run_op(4'h2, 4'h3, 2'b00, 1'b0, 1'b0, lat);
        n_chk++;
        if (lat !== W || out_s !== 4'h5 || out_c !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_add: got lat=%0d s=%h c=%b want lat=%0d s=5 c=0", lat, out_s, out_c, W);
        end
        consume();
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] a, b;
        logic [1:0]   op;
        logic         binv, cin;
        logic [W+2:0] exp;
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom); b = W'($urandom); op = 2'($urandom);
            binv = 1'($urandom); cin = 1'($urandom);
            exp = model(a, b, op, binv, cin);
            run_op(a, b, op, binv, cin, lat);
            n_chk++;
            if (lat !== W || {out_s, out_c, out_z, out_v} !== exp) begin
                n_fail++;
                $display("FAIL rand_%0d: got lat=%0d {s,c,z,v}=%h want lat=%0d {s,c,z,v}=%h",
                         i, lat, {out_s, out_c, out_z, out_v}, W, exp);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        logic [W+2:0] expq[$];
        logic [W+2:0] exp;
        int last_acc = -1;
        int n_acc = 0;
        int n_res = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 72; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (out_valid) begin
                n_chk++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra_result: got s=%h with no outstanding op want none", out_s);
                end else begin
                    exp = expq.pop_front();
                    n_res++;
                    $display("b2b result %0d: s=%h c=%b z=%b v=%b", n_res, out_s, out_c, out_z, out_v);
                    if ({out_s, out_c, out_z, out_v} !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_result_%0d: got {s,c,z,v}=%h want %h",
                                 n_res, {out_s, out_c, out_z, out_v}, exp);
                    end
                end
            end
            in_a = W'($urandom); in_b = W'($urandom); in_op = 2'($urandom);
            in_binv = 1'($urandom); in_cin = 1'($urandom);
            if (in_ready) begin
                expq.push_back(model(in_a, in_b, in_op, in_binv, in_cin));
                n_acc++;
                if (last_acc >= 0) begin
                    n_chk++;
                    if (cyc - last_acc !== W + 2) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: got %0d cycles want %0d", cyc - last_acc, W + 2);
                    end
                end
                last_acc = cyc;
            end
            @(posedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && expq.size() > 0; i++) begin
            @(negedge clk);
            if (out_valid) begin
                exp = expq.pop_front();
                n_res++;
                n_chk++;
                if ({out_s, out_c, out_z, out_v} !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_drain_%0d: got {s,c,z,v}=%h want %h",
                             n_res, {out_s, out_c, out_z, out_v}, exp);
                end
            end
            @(posedge clk);
        end
        n_chk++;
        if (n_res !== n_acc || n_acc < 10) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results for %0d accepts want equal and >= 10", n_res, n_acc);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
